// File: rtl/lerp2_seq.sv
// Bilinear interpolator that time-shares one fixed-point divider across its three correction terms.
// Optional feature macro: LERP2_SEQ_SKIP_EN (skip divisions whose numerator is exactly zero).

module div #(
    parameter int WIDTH = 32,
    parameter int FBITS = 16,
    parameter int LAT   = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    valid,
    output logic                    dbz,
    output logic                    ovf,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] val
);
    localparam int CW = $clog2(LAT + 1);

    logic        [CW-1:0]      r_cnt;
    logic                      r_busy;
    logic                      r_dbz;
    logic                      r_ovf;
    logic signed [WIDTH-1:0]   r_q;
    logic signed [2*WIDTH-1:0] w_num;
    logic signed [2*WIDTH-1:0] w_den;
    logic signed [2*WIDTH-1:0] w_quo;
    logic                      w_dbz;
    logic                      w_ovf;

    // Quotient (a << FBITS) / b, truncated toward zero, with range check.
    always_comb begin
        w_num = {{WIDTH{a[WIDTH-1]}}, a};
        w_num = w_num <<< FBITS;
        w_den = {{WIDTH{b[WIDTH-1]}}, b};
        w_dbz = (b == {WIDTH{1'b0}});
        if (w_dbz) begin
            w_quo = {(2*WIDTH){1'b0}};
        end else begin
            w_quo = w_num / w_den;
        end
        w_ovf = !w_dbz && (w_quo[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){1'b0}})
                       && (w_quo[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){1'b1}});
    end

    // Latch the result on start, then count down LAT cycles to done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_cnt  <= {CW{1'b0}};
            r_q    <= {WIDTH{1'b0}};
            r_dbz  <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (start && !r_busy) begin
            r_busy <= 1'b1;
            r_cnt  <= CW'(LAT - 1);
            r_dbz  <= w_dbz;
            r_ovf  <= w_ovf;
            if (w_dbz || w_ovf) begin
                r_q <= {WIDTH{1'b0}};
            end else begin
                r_q <= w_quo[WIDTH-1:0];
            end
        end else if (r_busy && (r_cnt == {CW{1'b0}})) begin
            r_busy <= 1'b0;
        end else if (r_busy) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign busy  = r_busy;
    assign done  = r_busy && (r_cnt == {CW{1'b0}});
    assign valid = done && !r_dbz && !r_ovf;
    assign dbz   = done && r_dbz;
    assign ovf   = done && r_ovf;
    assign val   = r_q;
endmodule

module lerp2_seq #(
    parameter int WIDTH   = 32,
    parameter int FBITS   = 16,
    parameter int DIV_LAT = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] p0,
    input  logic signed [WIDTH-1:0] p1,
    input  logic signed [WIDTH-1:0] p2,
    input  logic signed [WIDTH-1:0] p3,
    input  logic signed [WIDTH-1:0] x,
    input  logic signed [WIDTH-1:0] y,
    input  logic signed [WIDTH-1:0] X,
    input  logic signed [WIDTH-1:0] Y,
    output logic signed [WIDTH-1:0] val,
    output logic                    done,
    output logic                    busy,
    output logic                    err
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2, S_SUM = 2'd3} state_t;

    function automatic logic signed [WIDTH-1:0] fx_mul(input logic signed [WIDTH-1:0] a,
                                                       input logic signed [WIDTH-1:0] b);
        logic signed [2*WIDTH-1:0] p;
        p = a * b;
        return p[FBITS +: WIDTH];
    endfunction

`ifdef LERP2_SEQ_SKIP_EN
    // First term index >= from with a nonzero numerator; 3 means none left.
    function automatic logic [1:0] first_nz(input logic [1:0] from, input logic [2:0] nz);
        logic [1:0] r;
        if (from == 2'd0 && nz[0])      r = 2'd0;
        else if (from <= 2'd1 && nz[1]) r = 2'd1;
        else if (from <= 2'd2 && nz[2]) r = 2'd2;
        else                            r = 2'd3;
        return r;
    endfunction
`endif

    state_t                  r_state, w_state_nx;
    logic [1:0]              r_k, w_k_nx, w_issue_k, w_next_k, w_sel_k;
    logic signed [WIDTH-1:0] r_p0, r_p1, r_p2, r_p3, r_x, r_y, r_xx, r_yy;
    logic signed [WIDTH-1:0] r_acc, r_val;
    logic                    r_done, r_busy, r_err;
    logic signed [WIDTH-1:0] w_num [3];
    logic signed [WIDTH-1:0] w_den [3];
    logic signed [WIDTH-1:0] w_div_a, w_div_b, w_div_val, w_term, w_acc_sum;
    logic                    w_div_start, w_div_busy, w_div_done, w_div_valid, w_div_dbz, w_div_ovf;
    logic                    w_accept, w_capture, w_finish;

    div #(.WIDTH(WIDTH), .FBITS(FBITS), .LAT(DIV_LAT)) u_div (
        .clk(clock), .rst(reset), .start(w_div_start), .busy(w_div_busy), .done(w_div_done),
        .valid(w_div_valid), .dbz(w_div_dbz), .ovf(w_div_ovf), .a(w_div_a), .b(w_div_b),
        .val(w_div_val)
    );

    // Numerator/denominator pairs for the three terms from the latched operands.
    always_comb begin
        w_num[0] = fx_mul(r_p1 - r_p0, r_x);
        w_num[1] = fx_mul(r_p2 - r_p0, r_y);
        w_num[2] = fx_mul(fx_mul(r_p0 - r_p1 + r_p3 - r_p2, r_x), r_y);
        w_den[0] = r_xx;
        w_den[1] = r_yy;
        w_den[2] = fx_mul(r_xx, r_yy);
    end

`ifdef LERP2_SEQ_SKIP_EN
    logic [2:0] w_nz;
    assign w_nz      = {w_num[2] != {WIDTH{1'b0}}, w_num[1] != {WIDTH{1'b0}}, w_num[0] != {WIDTH{1'b0}}};
    assign w_issue_k = first_nz(r_k, w_nz);
    assign w_next_k  = first_nz(r_k + 2'd1, w_nz);
`else
    assign w_issue_k = r_k;
    assign w_next_k  = r_k + 2'd1;
`endif

    // Divider operands stay on the issued term for the whole WAIT.
    always_comb begin
        w_sel_k = (r_state == S_ISSUE) ? w_issue_k : r_k;
        case (w_sel_k)
            2'd0:    begin w_div_a = w_num[0]; w_div_b = w_den[0]; end
            2'd1:    begin w_div_a = w_num[1]; w_div_b = w_den[1]; end
            2'd2:    begin w_div_a = w_num[2]; w_div_b = w_den[2]; end
            default: begin w_div_a = {WIDTH{1'b0}}; w_div_b = {WIDTH{1'b0}}; end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_k     <= 2'd0;
        end else begin
            r_state <= w_state_nx;
            r_k     <= w_k_nx;
        end
    end

    // Next-state and control strobes.
    always_comb begin
        w_state_nx  = r_state;
        w_k_nx      = r_k;
        w_div_start = 1'b0;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept   = 1'b1;
                    w_state_nx = S_ISSUE;
                    w_k_nx     = 2'd0;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (w_issue_k == 2'd3) begin
                    w_finish   = 1'b1;
                    w_state_nx = S_SUM;
                end else if (!w_div_busy) begin
                    w_div_start = 1'b1;
                    w_k_nx      = w_issue_k;
                    w_state_nx  = S_WAIT;
                end else begin
                    w_state_nx = S_ISSUE;
                end
            end
            S_WAIT: begin
                if (w_div_done) begin
                    w_capture = 1'b1;
                    if (w_next_k == 2'd3) begin
                        w_finish   = 1'b1;
                        w_state_nx = S_SUM;
                    end else begin
                        w_k_nx     = w_next_k;
                        w_state_nx = S_ISSUE;
                    end
                end else begin
                    w_state_nx = S_WAIT;
                end
            end
            S_SUM:   w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // A failed division contributes zero to the running sum.
    always_comb begin
        if (w_capture && w_div_valid && !w_div_dbz && !w_div_ovf) begin
            w_term = w_div_val;
        end else begin
            w_term = {WIDTH{1'b0}};
        end
        w_acc_sum = r_acc + w_term;
    end

    // Operand latch, running sum and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_p0 <= {WIDTH{1'b0}}; r_p1 <= {WIDTH{1'b0}}; r_p2 <= {WIDTH{1'b0}}; r_p3 <= {WIDTH{1'b0}};
            r_x  <= {WIDTH{1'b0}}; r_y  <= {WIDTH{1'b0}}; r_xx <= {WIDTH{1'b0}}; r_yy <= {WIDTH{1'b0}};
            r_acc  <= {WIDTH{1'b0}};
            r_val  <= {WIDTH{1'b0}};
            r_done <= 1'b0;
            r_busy <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= w_finish;
            r_busy <= (w_state_nx != S_IDLE);
            if (w_accept) begin
                r_p0 <= p0; r_p1 <= p1; r_p2 <= p2; r_p3 <= p3;
                r_x  <= x;  r_y  <= y;  r_xx <= X;  r_yy <= Y;
                r_acc <= p0;
                r_err <= 1'b0;
            end else if (w_capture) begin
                r_acc <= w_acc_sum;
                if (w_div_dbz || w_div_ovf || !w_div_valid) begin
                    r_err <= 1'b1;
                end else begin
                    r_err <= r_err;
                end
            end
            if (w_finish) begin
                r_val <= w_acc_sum;
            end else begin
                r_val <= r_val;
            end
        end
    end

    assign val  = r_val;
    assign done = r_done;
    assign busy = r_busy;
    assign err  = r_err;
endmodule

// File: tb/tb_lerp2_seq.sv
// Self-checking bench for lerp2_seq: directed table, random vs. arithmetic model, handshake and reset sequences.

module tb_lerp2_seq;
    localparam int L = 3;

    typedef struct {
        int p0; int p1; int p2; int p3; int x; int y; int xx; int yy;
        int ev; bit ee;
    } vec_t;

    logic clock = 1'b0;
    logic reset, start;
    logic signed [31:0] p0, p1, p2, p3, x, y, X, Y, val;
    logic done, busy, err;
    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    lerp2_seq #(.WIDTH(32), .FBITS(16), .DIV_LAT(L)) dut (
        .clock(clock), .reset(reset), .start(start),
        .p0(p0), .p1(p1), .p2(p2), .p3(p3), .x(x), .y(y), .X(X), .Y(Y),
        .val(val), .done(done), .busy(busy), .err(err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (done === 1'b1) done_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int fmul(input int a, input int b);
        longint pr;
        pr = longint'(a) * longint'(b);
        return int'(pr >>> 16);
    endfunction

    function automatic void fdiv(input int n, input int d, output int q, output bit e);
        longint t;
        if (d == 0) begin
            q = 0; e = 1'b1;
        end else begin
            t = (longint'(n) <<< 16) / longint'(d);
            if (t > 64'sd2147483647 || t < -64'sd2147483648) begin
                q = 0; e = 1'b1;
            end else begin
                q = int'(t); e = 1'b0;
            end
        end
    endfunction

    // Reference: val = p0 + sum of the three quotients; latency from how many divisions run.
    function automatic void model(input vec_t v, output int ev, output bit ee, output int elat);
        int n[3];
        int d[3];
        int q, cnt;
        bit e;
        n[0] = fmul(v.p1 - v.p0, v.x);
        n[1] = fmul(v.p2 - v.p0, v.y);
        n[2] = fmul(fmul(v.p0 - v.p1 + v.p3 - v.p2, v.x), v.y);
        d[0] = v.xx;
        d[1] = v.yy;
        d[2] = fmul(v.xx, v.yy);
        ev = v.p0; ee = 1'b0; cnt = 0;
        for (int i = 0; i < 3; i++) begin
`ifdef LERP2_SEQ_SKIP_EN
            if (n[i] == 0) continue;
`endif
            cnt++;
            fdiv(n[i], d[i], q, e);
            ev += q;
            ee |= e;
        end
        elat = cnt * (1 + L) + 1;
    endfunction

    task automatic drive(input vec_t v);
        p0 = v.p0; p1 = v.p1; p2 = v.p2; p3 = v.p3; x = v.x; y = v.y; X = v.xx; Y = v.yy;
    endtask

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic run_req(input vec_t v, output int gv, output bit ge, output int lat, output bit to);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 200) begin @(negedge clock); n++; end
        drive(v);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 200) begin @(negedge clock); n++; end
        lat = 1 + n;
        to = (done !== 1'b1);
        gv = val;
        ge = err;
    endtask

    task automatic run_and_check(input string tag, input vec_t v, input int ev, input bit ee);
        int gv, lat, mv, mlat, d0;
        bit ge, to, me;
        model(v, mv, me, mlat);
        d0 = done_cnt;
        run_req(v, gv, ge, lat, to);
        chk({tag, "_timeout"}, to, 1'b0);
        chk({tag, "_val"}, gv, ev);
        chk({tag, "_err"}, ge, ee);
        if (mlat > 1) chk({tag, "_lat"}, lat, mlat);
        repeat (2) @(negedge clock);
        chk({tag, "_ndone"}, done_cnt - d0, 1);
    endtask

    initial begin
        vec_t tbl[6];
        vec_t v, junk;
        int gv, lat, d0, n, nd, mv, mlat;
        int t[3];
        bit ge, to, me;

        tbl[0] = '{0, 32'h10000, 32'h20000, 32'h30000, 32'h20000, 32'h20000, 32'h40000, 32'h40000, 32'h18000, 1'b0};
        tbl[1] = '{0, 32'h10000, 32'h20000, 32'h40000, 32'h20000, 32'h20000, 32'h40000, 32'h40000, 32'h1C000, 1'b0};
        tbl[2] = '{0, 32'h12345, 32'h20000, 32'h30000, 32'h40000, 0,          32'h40000, 32'h40000, 32'h12345, 1'b0};
        tbl[3] = '{0, 32'h10000, 32'h20000, 32'h30000, 0,          32'h40000, 32'h40000, 32'h40000, 32'h20000, 1'b0};
        tbl[4] = '{0, 32'h10000, 32'h20000, 32'h30000, 32'h20000, 32'h20000, 0,          32'h40000, 32'h10000, 1'b1};
        tbl[5] = tbl[0];

        reset = 1'b1; start = 1'b0;
        drive(tbl[0]);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_val", val, 32'h0);
        chk("rst_done", done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);

        for (int i = 0; i < 6; i++) run_and_check($sformatf("vec%0d", i), tbl[i], tbl[i].ev, tbl[i].ee);

        for (int i = 0; i < 20; i++) begin
            v.p0 = int'($urandom_range(0, 32'h80000)) - 32'h40000;
            v.p1 = int'($urandom_range(0, 32'h80000)) - 32'h40000;
            v.p2 = int'($urandom_range(0, 32'h80000)) - 32'h40000;
            v.p3 = int'($urandom_range(0, 32'h80000)) - 32'h40000;
            v.x  = int'($urandom_range(0, 32'h40000));
            v.y  = int'($urandom_range(0, 32'h40000));
            v.xx = int'($urandom_range(32'h8000, 32'h80000));
            v.yy = int'($urandom_range(32'h8000, 32'h80000));
            if (i % 7 == 3) v.xx = 0;
            if (i % 5 == 4) v.yy = 1;
            model(v, mv, me, mlat);
            run_and_check($sformatf("rnd%0d", i), v, mv, me);
        end

        // Extra start pulses and operand changes while busy must be ignored.
        junk = '{32'h5000, 32'h70000, 32'h1000, 32'h9000, 32'h30000, 32'h10000, 32'h20000, 32'h60000, 0, 1'b0};
        d0 = done_cnt;
        drive(tbl[1]);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("hs_busy", busy, 1'b1);
            drive(junk);
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
        end
        n = 0;
        while (done !== 1'b1 && n < 200) begin @(negedge clock); n++; end
        chk("hs_timeout", done, 1'b1);
        chk("hs_val", val, 32'h1C000);
        repeat (20) @(negedge clock);
        chk("hs_ndone", done_cnt - d0, 1);

        // start held high: back-to-back results spaced by latency plus the accept cycle.
        model(tbl[0], mv, me, mlat);
        drive(tbl[0]);
        start = 1'b1;
        nd = 0; n = 0;
        while (nd < 3 && n < 300) begin
            @(negedge clock);
            n++;
            if (done === 1'b1) begin
                t[nd] = n;
                chk("b2b_val", val, 32'h18000);
                nd++;
            end
        end
        start = 1'b0;
        chk("b2b_count", nd, 3);
        if (nd == 3) begin
            chk("b2b_gap1", t[1] - t[0], mlat + 1);
            chk("b2b_gap2", t[2] - t[1], mlat + 1);
        end
        repeat (3) @(negedge clock);

        // Reset during the second WAIT aborts with no done pulse.
        drive(tbl[4]);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (6) @(negedge clock);
        chk("mid_err_before", err, 1'b1);
        d0 = done_cnt;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("mid_busy", busy, 1'b0);
        chk("mid_done", done, 1'b0);
        chk("mid_val", val, 32'h0);
        chk("mid_err", err, 1'b0);
        repeat (20) @(negedge clock);
        chk("mid_nodone", done_cnt - d0, 0);
        run_and_check("after_rst", tbl[0], 32'h18000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
